// File: rtl/demux8_buf_if.sv
// Handshake bundle for demux8_buf: one input stream in, eight buffered channels out.
interface demux8_buf_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_sel;
  logic               in_bcast;
  logic [WIDTH-1:0]   in_data;
  logic [7:0]         out_valid;
  logic [7:0]         out_ready;
  logic [8*WIDTH-1:0] out_data;
  logic               busy;
  logic [15:0]        xfer_cnt;

  modport master (
    output in_valid, in_sel, in_bcast, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, xfer_cnt
  );

  modport slave (
    input  in_valid, in_sel, in_bcast, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, xfer_cnt
  );
endinterface

// File: rtl/demux8_buf.sv
// 1:8 registered demultiplexer with a one-entry buffer per channel and a
// broadcast mode that loads all eight channels from a single input beat.
module demux8_buf #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  demux8_buf_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t      slot_p1      [8];
  logic [WIDTH-1:0] slot_data_p1 [8];
  logic [15:0]      xfer_cnt_p1;

  logic [7:0] vld_p1;
  logic [7:0] free;
  logic [7:0] load;
  logic       accept;

  // A full slot whose consumer is taking the beat this cycle can be refilled.
  assign free         = ~vld_p1 | bus.out_ready;
  assign bus.in_ready = bus.in_bcast ? (&free) : free[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_chan
      assign vld_p1[g]                       = (slot_p1[g] == FULL);
      assign load[g]                         = accept & (bus.in_bcast | (bus.in_sel == 3'(g)));
      assign bus.out_data[g*WIDTH +: WIDTH]  = slot_data_p1[g];
    end
  endgenerate

  assign bus.out_valid = vld_p1;
  assign bus.busy      = |vld_p1;
  assign bus.xfer_cnt  = xfer_cnt_p1;

  // Stage p0 -> p1: input beat lands in the selected slot(s).
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_p1 <= '0;
      for (int k = 0; k < 8; k++) begin
        slot_p1[k]      <= EMPTY;
        slot_data_p1[k] <= '0;
      end
    end else begin
      if (accept) begin
        xfer_cnt_p1 <= xfer_cnt_p1 + 16'd1;
      end
      for (int k = 0; k < 8; k++) begin
        case (slot_p1[k])
          EMPTY: begin
            if (load[k]) begin
              slot_p1[k]      <= FULL;
              slot_data_p1[k] <= bus.in_data;
            end
          end
          FULL: begin
            if (load[k]) begin
              slot_data_p1[k] <= bus.in_data;
            end else if (bus.out_ready[k]) begin
              slot_p1[k] <= EMPTY;
            end
          end
          default: slot_p1[k] <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux8_buf.sv
// Directed self-checking bench for demux8_buf.
module tb_demux8_buf;
  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   nvec;
  int   nfail;

  demux8_buf_if #(.WIDTH(WIDTH)) bus ();

  demux8_buf #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] ch(input int k);
    return bus.out_data[k*WIDTH +: WIDTH];
  endfunction

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_bcast  = 1'b0;
    bus.in_sel    = 3'd0;
    bus.in_data   = '0;
    bus.out_ready = 8'h00;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    nvec++; if (bus.out_valid !== 8'h00) begin nfail++; $display("FAIL reset_valid got=%h exp=00", bus.out_valid); end
    nvec++; if (bus.xfer_cnt !== 16'h0000) begin nfail++; $display("FAIL reset_cnt got=%h exp=0000", bus.xfer_cnt); end
    nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    nvec++; if (bus.out_data !== '0) begin nfail++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
  endtask

  task automatic test_reset_midop();
    idle();
    bus.in_valid = 1'b1; bus.in_sel = 3'd2; bus.in_data = 16'h2222;
    step();
    bus.in_sel = 3'd5; bus.in_data = 16'h5555;
    step();
    nvec++; if (bus.out_valid !== 8'h24) begin nfail++; $display("FAIL midop_fill got=%h exp=24", bus.out_valid); end
    // Same-cycle accept and drain must lose to reset.
    bus.in_sel = 3'd0; bus.in_data = 16'h0F0F; bus.out_ready = 8'h04;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    nvec++; if (bus.out_valid !== 8'h00) begin nfail++; $display("FAIL midop_valid got=%h exp=00", bus.out_valid); end
    nvec++; if (bus.xfer_cnt !== 16'h0000) begin nfail++; $display("FAIL midop_cnt got=%h exp=0000", bus.xfer_cnt); end
    nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL midop_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_single_steer();
    idle();
    bus.in_valid = 1'b1; bus.in_sel = 3'd3; bus.in_data = 16'hBEEF;
    #1;
    nvec++; if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL steer_ready got=%b exp=1", bus.in_ready); end
    nvec++; if (bus.out_valid !== 8'h00) begin nfail++; $display("FAIL steer_no_comb got=%h exp=00", bus.out_valid); end
    step();
    idle();
    nvec++; if (bus.out_valid !== 8'h08) begin nfail++; $display("FAIL steer_valid got=%h exp=08", bus.out_valid); end
    nvec++; if (ch(3) !== 16'hBEEF) begin nfail++; $display("FAIL steer_data got=%h exp=beef", ch(3)); end
    nvec++; if (bus.xfer_cnt !== 16'd1) begin nfail++; $display("FAIL steer_cnt got=%h exp=0001", bus.xfer_cnt); end
    nvec++; if (bus.busy !== 1'b1) begin nfail++; $display("FAIL steer_busy got=%b exp=1", bus.busy); end
  endtask

  task automatic test_backpressure();
    idle();
    bus.in_valid = 1'b1; bus.in_sel = 3'd3; bus.in_data = 16'h1111;
    #1;
    nvec++; if (bus.in_ready !== 1'b0) begin nfail++; $display("FAIL bp_ready3 got=%b exp=0", bus.in_ready); end
    step();
    nvec++; if (ch(3) !== 16'hBEEF) begin nfail++; $display("FAIL bp_hold3 got=%h exp=beef", ch(3)); end
    nvec++; if (bus.xfer_cnt !== 16'd1) begin nfail++; $display("FAIL bp_cnt_hold got=%h exp=0001", bus.xfer_cnt); end
    bus.in_sel = 3'd4; bus.in_data = 16'h4444;
    #1;
    nvec++; if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL bp_ready4 got=%b exp=1", bus.in_ready); end
    step();
    idle();
    nvec++; if (bus.out_valid !== 8'h18) begin nfail++; $display("FAIL bp_valid got=%h exp=18", bus.out_valid); end
    nvec++; if (ch(4) !== 16'h4444) begin nfail++; $display("FAIL bp_data4 got=%h exp=4444", ch(4)); end
    nvec++; if (ch(3) !== 16'hBEEF) begin nfail++; $display("FAIL bp_still3 got=%h exp=beef", ch(3)); end
    nvec++; if (bus.xfer_cnt !== 16'd2) begin nfail++; $display("FAIL bp_cnt got=%h exp=0002", bus.xfer_cnt); end
  endtask

  task automatic test_drain_refill();
    idle();
    bus.in_valid = 1'b1; bus.in_sel = 3'd3; bus.in_data = 16'h1234; bus.out_ready = 8'h08;
    #1;
    nvec++; if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL refill_ready got=%b exp=1", bus.in_ready); end
    step();
    idle();
    nvec++; if (bus.out_valid !== 8'h18) begin nfail++; $display("FAIL refill_valid got=%h exp=18", bus.out_valid); end
    nvec++; if (ch(3) !== 16'h1234) begin nfail++; $display("FAIL refill_data got=%h exp=1234", ch(3)); end
    nvec++; if (bus.xfer_cnt !== 16'd3) begin nfail++; $display("FAIL refill_cnt got=%h exp=0003", bus.xfer_cnt); end
    bus.out_ready = 8'h10;
    step();
    nvec++; if (bus.out_valid !== 8'h08) begin nfail++; $display("FAIL drain4_valid got=%h exp=08", bus.out_valid); end
    nvec++; if (ch(3) !== 16'h1234) begin nfail++; $display("FAIL drain4_keep3 got=%h exp=1234", ch(3)); end
    bus.out_ready = 8'hFF;
    step();
    idle();
    nvec++; if (bus.out_valid !== 8'h00) begin nfail++; $display("FAIL drain_all got=%h exp=00", bus.out_valid); end
    nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL drain_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_broadcast();
    idle();
    bus.in_valid = 1'b1; bus.in_bcast = 1'b1; bus.in_sel = 3'd6; bus.in_data = 16'hA5A5;
    #1;
    nvec++; if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL bc_ready got=%b exp=1", bus.in_ready); end
    step();
    idle();
    nvec++; if (bus.out_valid !== 8'hFF) begin nfail++; $display("FAIL bc_valid got=%h exp=ff", bus.out_valid); end
    nvec++; if (bus.out_data !== {8{16'hA5A5}}) begin nfail++; $display("FAIL bc_data got=%h exp=all a5a5", bus.out_data); end
    nvec++; if (bus.xfer_cnt !== 16'd4) begin nfail++; $display("FAIL bc_cnt got=%h exp=0004", bus.xfer_cnt); end
    bus.out_ready = 8'hBF;
    step();
    nvec++; if (bus.out_valid !== 8'h40) begin nfail++; $display("FAIL bc_drain got=%h exp=40", bus.out_valid); end
    bus.out_ready = 8'h00;
    bus.in_sel = 3'd0;
    #1;
    nvec++; if (bus.in_ready !== 1'b1) begin nfail++; $display("FAIL ready_novalid0 got=%b exp=1", bus.in_ready); end
    bus.in_sel = 3'd6;
    #1;
    nvec++; if (bus.in_ready !== 1'b0) begin nfail++; $display("FAIL ready_novalid6 got=%b exp=0", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_bcast = 1'b1; bus.in_sel = 3'd1; bus.in_data = 16'h5A5A;
    #1;
    nvec++; if (bus.in_ready !== 1'b0) begin nfail++; $display("FAIL bc_blocked got=%b exp=0", bus.in_ready); end
    step();
    idle();
    nvec++; if (bus.out_valid !== 8'h40) begin nfail++; $display("FAIL bc_nochg_valid got=%h exp=40", bus.out_valid); end
    nvec++; if (bus.out_data !== {8{16'hA5A5}}) begin nfail++; $display("FAIL bc_nochg_data got=%h exp=all a5a5", bus.out_data); end
    nvec++; if (bus.xfer_cnt !== 16'd4) begin nfail++; $display("FAIL bc_nochg_cnt got=%h exp=0004", bus.xfer_cnt); end
  endtask

  task automatic test_counter_wrap();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.in_sel = 3'd7; bus.out_ready = 8'hFF;
    for (int i = 0; i < 65535; i++) begin
      bus.in_data = 16'(i);
      step();
    end
    nvec++; if (bus.xfer_cnt !== 16'hFFFF) begin nfail++; $display("FAIL wrap_pre got=%h exp=ffff", bus.xfer_cnt); end
    nvec++; if (ch(7) !== 16'hFFFE) begin nfail++; $display("FAIL wrap_order got=%h exp=fffe", ch(7)); end
    bus.in_data = 16'hCAFE;
    step();
    idle();
    nvec++; if (bus.xfer_cnt !== 16'h0000) begin nfail++; $display("FAIL wrap_cnt got=%h exp=0000", bus.xfer_cnt); end
    nvec++; if (ch(7) !== 16'hCAFE) begin nfail++; $display("FAIL wrap_data got=%h exp=cafe", ch(7)); end
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_reset_midop();
    test_single_steer();
    test_backpressure();
    test_drain_refill();
    test_broadcast();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
